// File: rtl/exmem_pkg.sv
// Shared types for the EX/MEM pipeline register: control bundle, default-width
// entry layout and the all-zero bubble.
package exmem_pkg;

   localparam int EXMEM_XLEN    = 64;
   localparam int EXMEM_RADDR_W = 5;

   typedef struct packed {
      logic memto_reg;
      logic reg_write;
      logic branch;
      logic mem_read;
      logic mem_write;
   } exmem_ctrl_t;

   // Reference layout at the core's native widths; the top rebuilds the same
   // field order from its own parameters.
   typedef struct packed {
      logic                     valid;
      exmem_ctrl_t              ctrl;
      logic                     zero;
      logic [EXMEM_RADDR_W-1:0] rd;
      logic [EXMEM_XLEN-1:0]    adder;
      logic [EXMEM_XLEN-1:0]    alu_result;
      logic [EXMEM_XLEN-1:0]    read_data2;
   } exmem_entry_t;

   localparam exmem_entry_t EXMEM_BUBBLE = '0;

endpackage

// File: rtl/exmem_stage.sv
// One EX/MEM register stage: holds on hold, loads zero on kill, else loads d.
module exmem_stage
   import exmem_pkg::*;
#(
   parameter int W = $bits(exmem_entry_t)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         hold,
   input  logic         kill,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] q_d;
   logic [W-1:0] q_q;

   always_comb begin
      q_d = q_q;
      if (!hold) begin
         q_d = kill ? '0 : d;
      end
   end

   // NOTE: state updates use <= so every stage samples its neighbour's old value.
   always_ff @(posedge clk) begin
      if (reset) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/exmem_pipe.sv
// Parametrised EX/MEM pipeline register: DEPTH stages with valid, stall, flush,
// registered branch decision and saturating stall/flush counters.
module exmem_pipe
   import exmem_pkg::*;
#(
   parameter int XLEN    = 64,
   parameter int RADDR_W = 5,
   parameter int DEPTH   = 1,
   parameter int COUNT_W = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               stall,
   input  logic               flush,
   input  logic               valid_in,
   input  logic [XLEN-1:0]    adder_in,
   input  logic               zero_in,
   input  logic [XLEN-1:0]    alu_result_in,
   input  logic [XLEN-1:0]    read_data2_in,
   input  logic [RADDR_W-1:0] rd_in,
   input  logic               memto_reg_in,
   input  logic               reg_write_in,
   input  logic               branch_in,
   input  logic               mem_read_in,
   input  logic               mem_write_in,
   output logic [XLEN-1:0]    adder_out,
   output logic [XLEN-1:0]    alu_result_out,
   output logic [XLEN-1:0]    read_data2_out,
   output logic               zero_out,
   output logic [RADDR_W-1:0] rd_out,
   output logic               memto_reg_out,
   output logic               reg_write_out,
   output logic               branch_out,
   output logic               mem_read_out,
   output logic               mem_write_out,
   output logic               valid_out,
   output logic               pc_src,
   output logic [COUNT_W-1:0] stall_count,
   output logic [COUNT_W-1:0] flush_count
);

   typedef struct packed {
      logic               valid;
      exmem_ctrl_t        ctrl;
      logic               zero;
      logic [RADDR_W-1:0] rd;
      logic [XLEN-1:0]    adder;
      logic [XLEN-1:0]    alu_result;
      logic [XLEN-1:0]    read_data2;
   } entry_t;

   localparam int ENTRY_W = $bits(entry_t);

   entry_t chain [DEPTH+1];
   logic   kill0;

   always_comb begin
      chain[0].valid          = valid_in;
      chain[0].ctrl.memto_reg = memto_reg_in;
      chain[0].ctrl.reg_write = reg_write_in;
      chain[0].ctrl.branch    = branch_in;
      chain[0].ctrl.mem_read  = mem_read_in;
      chain[0].ctrl.mem_write = mem_write_in;
      chain[0].zero           = zero_in;
      chain[0].rd             = rd_in;
      chain[0].adder          = adder_in;
      chain[0].alu_result     = alu_result_in;
      chain[0].read_data2     = read_data2_in;
   end

   // Later stages never need a kill: an invalid upstream entry is already all-zero.
   assign kill0 = flush | ~valid_in;

   for (genvar g = 0; g < DEPTH; g++) begin : g_stage
      exmem_stage #(.W(ENTRY_W)) u_stage (
         .clk   (clk),
         .reset (reset),
         .hold  (stall),
         .kill  ((g == 0) ? kill0 : 1'b0),
         .d     (chain[g]),
         .q     (chain[g+1])
      );
   end

   assign valid_out      = chain[DEPTH].valid;
   assign memto_reg_out  = chain[DEPTH].ctrl.memto_reg;
   assign reg_write_out  = chain[DEPTH].ctrl.reg_write;
   assign branch_out     = chain[DEPTH].ctrl.branch;
   assign mem_read_out   = chain[DEPTH].ctrl.mem_read;
   assign mem_write_out  = chain[DEPTH].ctrl.mem_write;
   assign zero_out       = chain[DEPTH].zero;
   assign rd_out         = chain[DEPTH].rd;
   assign adder_out      = chain[DEPTH].adder;
   assign alu_result_out = chain[DEPTH].alu_result;
   assign read_data2_out = chain[DEPTH].read_data2;
   assign pc_src         = branch_out & zero_out & valid_out;

   logic [COUNT_W-1:0] stall_count_d, stall_count_q;
   logic [COUNT_W-1:0] flush_count_d, flush_count_q;

   always_comb begin
      stall_count_d = stall_count_q;
      flush_count_d = flush_count_q;
      if (stall && (stall_count_q != '1)) begin
         stall_count_d = stall_count_q + COUNT_W'(1);
      end
      if (flush && !stall && (flush_count_q != '1)) begin
         flush_count_d = flush_count_q + COUNT_W'(1);
      end
   end

   // NOTE: only control/counter state is reset here; no storage arrays are involved.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_count_q <= '0;
         flush_count_q <= '0;
      end else begin
         stall_count_q <= stall_count_d;
         flush_count_q <= flush_count_d;
      end
   end

   assign stall_count = stall_count_q;
   assign flush_count = flush_count_q;

endmodule
